// File: rtl/byte_encode_stream.sv
// ML-KEM ByteEncode_d packer: 256 coefficients in, 32*D bytes out, LSB-first bit stream.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module byte_encode_stream #(
  parameter int D        = 12,
  parameter int IN_WIDTH = 16,
  parameter int ACC_W    = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IN_WIDTH-1:0] coef_i,
  input  logic                coef_valid_i,
  output logic                coef_ready_o,
  output logic [7:0]          byte_o,
  output logic                byte_valid_o,
  input  logic                byte_ready_i,
  output logic                byte_last_o,
  output logic                range_err_o
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int BYTES = 32 * D;
  localparam int BC_W  = $clog2(BYTES);

  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ACC_W - D);
  localparam logic [CNT_W-1:0] EIGHT     = CNT_W'(8);
  localparam logic [CNT_W-1:0] D_BITS    = CNT_W'(D);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES - 1);

  if (D < 1 || D > 12 || IN_WIDTH < D || ACC_W < D + 8) begin : g_bad_params
    $error("byte_encode_stream: illegal parameter combination");
  end

  logic [ACC_W-1:0] acc, acc_shifted, acc_next;
  logic [CNT_W-1:0] cnt, cnt_shifted, cnt_next;
  logic [7:0]       coef_cnt;
  logic [BC_W-1:0]  byte_cnt;
  logic             push, pop;

  // The pop shift is applied before the push so a simultaneous push lands at cnt-8.
  always_comb begin
    pop         = (cnt >= EIGHT) && (!byte_valid_o || byte_ready_i);
    push        = coef_valid_i && coef_ready_o;
    acc_shifted = acc;
    cnt_shifted = cnt;
    if (pop) begin
      acc_shifted = acc >> 8;
      cnt_shifted = cnt - EIGHT;
    end
    acc_next = acc_shifted;
    cnt_next = cnt_shifted;
    if (push) begin
      acc_next = acc_shifted | (ACC_W'(coef_i[D-1:0]) << cnt_shifted);
      cnt_next = cnt_shifted + D_BITS;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc          <= '0;
      cnt          <= '0;
      coef_cnt     <= '0;
      byte_cnt     <= '0;
      coef_ready_o <= 1'b0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      byte_last_o  <= 1'b0;
    end else begin
      acc          <= acc_next;
      cnt          <= cnt_next;
      coef_ready_o <= (cnt_next <= READY_MAX);
      if (push) coef_cnt <= coef_cnt + 8'd1;
      if (pop) begin
        byte_o       <= acc[7:0];
        byte_valid_o <= 1'b1;
        byte_last_o  <= (byte_cnt == LAST_BYTE);
        byte_cnt     <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BC_W'(1);
      end else if (byte_ready_i) begin
        byte_valid_o <= 1'b0;
      end
    end
  end

  if (D == 12) begin : g_range
    always_ff @(posedge clk_i) begin
      if (rst_i) range_err_o <= 1'b0;
      else if (push && (coef_i[11:0] >= 12'd3329)) range_err_o <= 1'b1;
    end
  end else begin : g_no_range
    assign range_err_o = 1'b0;
  end

  if (IN_WIDTH > D) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^coef_i[IN_WIDTH-1:D];
  end

  // Bits held always equal bits pushed minus bits popped, modulo one polynomial.
  a_bit_balance: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(cnt) == ((D * int'(coef_cnt) + 256 * D - 8 * int'(byte_cnt)) % (256 * D)));

endmodule

// File: tb/tb_byte_encode_stream.sv
// Bench for byte_encode_stream: D=12, D=8 and D=1 instances checked against a bit-array packing model.
module tb_byte_encode_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] coef = '0;
  logic        coef_valid = 1'b0;
  logic        byte_ready = 1'b1;
  int          sel = 0;
  bit          bp_en = 1'b0;

  always #5 clk = ~clk;

  logic       r12, r8, r1, bv12, bv8, bv1, l12, l8, l1, e12, e8, e1;
  logic [7:0] b12, b8, b1;
  logic       cur_coef_ready, cur_valid, cur_last, cur_err;
  logic [7:0] cur_byte;
  int         cur_d;

  byte_encode_stream #(.D(12), .IN_WIDTH(16), .ACC_W(24)) u_d12 (
    .clk_i(clk), .rst_i(rst), .coef_i(coef), .coef_valid_i(coef_valid && sel == 0),
    .coef_ready_o(r12), .byte_o(b12), .byte_valid_o(bv12), .byte_ready_i(byte_ready),
    .byte_last_o(l12), .range_err_o(e12));
  byte_encode_stream #(.D(8), .IN_WIDTH(16), .ACC_W(24)) u_d8 (
    .clk_i(clk), .rst_i(rst), .coef_i(coef), .coef_valid_i(coef_valid && sel == 1),
    .coef_ready_o(r8), .byte_o(b8), .byte_valid_o(bv8), .byte_ready_i(byte_ready),
    .byte_last_o(l8), .range_err_o(e8));
  byte_encode_stream #(.D(1), .IN_WIDTH(16), .ACC_W(24)) u_d1 (
    .clk_i(clk), .rst_i(rst), .coef_i(coef), .coef_valid_i(coef_valid && sel == 2),
    .coef_ready_o(r1), .byte_o(b1), .byte_valid_o(bv1), .byte_ready_i(byte_ready),
    .byte_last_o(l1), .range_err_o(e1));

  always_comb begin
    cur_d = 12; cur_coef_ready = r12; cur_byte = b12; cur_valid = bv12; cur_last = l12; cur_err = e12;
    if (sel == 1) begin
      cur_d = 8; cur_coef_ready = r8; cur_byte = b8; cur_valid = bv8; cur_last = l8; cur_err = e8;
    end else if (sel == 2) begin
      cur_d = 1; cur_coef_ready = r1; cur_byte = b1; cur_valid = bv1; cur_last = l1; cur_err = e1;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] coefs[512];
  logic [7:0]  exp_q[$];
  bit          exp_last_q[$];
  logic [7:0]  got_q[$];
  int          acc_n, taken_n, cyc, stall_n, last_cnt, last_idx;
  int          first_acc_cyc, first_take_cyc, last_take_cyc;
  bit          err_m, hold_pending;
  logic [7:0]  hold_byte;
  logic        hold_last;
  logic        rst_seen = 1'b1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: lay the coefficients out as one flat bit array and cut it into bytes.
  task automatic build_expected(input int d, input int first, input int n);
    int p;
    logic [7:0] b;
    for (int k = 0; k < (n * d) / 8; k++) begin
      b = '0;
      for (int bb = 0; bb < 8; bb++) begin
        p = 8 * k + bb;
        b[bb] = coefs[first + p / d][p % d];
      end
      exp_q.push_back(b);
      exp_last_q.push_back(k == 32 * d - 1);
    end
  endtask

  function automatic int decode(input int d, input int base, input int i);
    int v, p;
    logic [7:0] b;
    v = 0;
    for (int j = 0; j < d; j++) begin
      p = i * d + j;
      b = got_q[base + p / 8];
      v = v | (int'(b[p % 8]) << j);
    end
    return v;
  endfunction

  always @(posedge clk) rst_seen <= rst;

  initial forever begin
    @(posedge clk);
    #1;
    byte_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Compare process: outputs are sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    logic [7:0] eb;
    bit el;
    int bits;
    if (rst) begin
      if (rst_seen)
        check(!cur_valid && cur_byte == 0 && !cur_last && !cur_err && !cur_coef_ready, "reset_outputs",
              {cur_valid, cur_last, cur_err, cur_coef_ready, cur_byte}, 0);
      exp_q.delete(); exp_last_q.delete(); got_q.delete();
      acc_n = 0; taken_n = 0; cyc = 0; stall_n = 0; last_cnt = 0; last_idx = -1;
      first_acc_cyc = -1; first_take_cyc = -1; last_take_cyc = -1;
      err_m = 0; hold_pending = 0;
    end else begin
      cyc++;
      bits = cur_d * acc_n - 8 * (taken_n + int'(cur_valid));
      if (!rst_seen) begin
        check(cur_coef_ready == (bits <= 24 - cur_d), "coef_ready", cur_coef_ready, bits);
        if (coef_valid && !cur_coef_ready) stall_n++;
      end
      check(cur_err == err_m, "range_err", cur_err, err_m);
      if (hold_pending)
        check(cur_valid && cur_byte == hold_byte && cur_last == hold_last, "hold_stable", cur_byte, hold_byte);
      if (cur_valid && byte_ready) begin
        if (exp_q.size() == 0) check(0, "extra_byte", cur_byte, -1);
        else begin
          eb = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check(cur_byte == eb, "byte_value", cur_byte, eb);
          check(cur_last == el, "byte_last", cur_last, el);
        end
        got_q.push_back(cur_byte);
        if (cur_last) begin last_cnt++; last_idx = got_q.size() - 1; end
        taken_n++;
        if (first_take_cyc < 0) first_take_cyc = cyc;
        last_take_cyc = cyc;
      end
      hold_pending = cur_valid && !byte_ready;
      hold_byte = cur_byte;
      hold_last = cur_last;
      if (coef_valid && cur_coef_ready) begin
        acc_n++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        if (cur_d == 12 && coef[11:0] >= 12'd3329) err_m = 1;
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    coef_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input int first, input int n);
    int waitc;
    for (int i = first; i < first + n; i++) begin
      coef = coefs[i];
      coef_valid = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!cur_coef_ready && waitc < 100) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 100) begin
        check(0, "coef_ready_timeout", waitc, 100);
        break;
      end
      @(posedge clk);
      #1;
    end
    coef_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cur_valid) && k < 4000) begin
      @(posedge clk);
      k++;
    end
    check(k < 4000, "drain_timeout", k, 4000);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int mism;
    // D=12 ramp followed back-to-back by a random polynomial with junk upper bits.
    sel = 0;
    do_reset(3);
    for (int i = 0; i < 256; i++) coefs[i] = 16'(i % 3329);
    for (int i = 256; i < 512; i++)
      coefs[i] = 16'($urandom_range(0, 3328)) | 16'($urandom_range(0, 15) << 12);
    build_expected(12, 0, 256);
    build_expected(12, 256, 256);
    send(0, 512);
    drain();
    check(got_q.size() == 768, "d12_byte_count", got_q.size(), 768);
    check(got_q[0] == 8'h00, "d12_byte0", got_q[0], 8'h00);
    check(got_q[1] == 8'h10, "d12_byte1", got_q[1], 8'h10);
    check(got_q[2] == 8'h00, "d12_byte2", got_q[2], 8'h00);
    check(last_cnt == 2 && last_idx == 767, "d12_last_pos", last_idx, 767);
    check(cur_err == 1'b0, "d12_no_range_err", cur_err, 0);
    mism = 0;
    for (int i = 0; i < 512; i++)
      if (decode(12, (i / 256) * 384, i % 256) != int'(coefs[i] & 16'h0FFF)) mism++;
    check(mism == 0, "d12_roundtrip", mism, 0);

    // D=12 under random backpressure.
    do_reset(2);
    bp_en = 1'b1;
    for (int i = 0; i < 256; i++) coefs[i] = 16'($urandom_range(0, 3328));
    build_expected(12, 0, 256);
    send(0, 256);
    drain();
    bp_en = 1'b0;
    check(got_q.size() == 384, "bp_byte_count", got_q.size(), 384);
    mism = 0;
    for (int i = 0; i < 256; i++) if (decode(12, 0, i) != int'(coefs[i])) mism++;
    check(mism == 0, "bp_roundtrip", mism, 0);

    // Out-of-range coefficient 5.
    do_reset(2);
    for (int i = 0; i < 256; i++) coefs[i] = '0;
    coefs[5] = 16'd3329;
    build_expected(12, 0, 256);
    send(0, 256);
    drain();
    check(cur_err == 1'b1, "range_err_sticky", cur_err, 1);
    check(got_q[7] == 8'h10, "err_byte7", got_q[7], 8'h10);
    check(got_q[8] == 8'hD0, "err_byte8", got_q[8], 8'hD0);
    check(decode(12, 0, 5) == 3329, "err_coef5", decode(12, 0, 5), 3329);

    // Reset after 100 coefficients, then a fresh polynomial.
    do_reset(2);
    for (int i = 0; i < 256; i++) coefs[i] = 16'($urandom_range(0, 4095));
    build_expected(12, 0, 100);
    send(0, 100);
    do_reset(2);
    for (int i = 0; i < 256; i++) coefs[i] = 16'((i * 7 + 3) % 3329);
    build_expected(12, 0, 256);
    send(0, 256);
    drain();
    check(got_q.size() == 384, "post_reset_count", got_q.size(), 384);
    check(last_cnt == 1 && last_idx == 383, "post_reset_last", last_idx, 383);

    // D=8 identity stream with continuous valid.
    sel = 1;
    do_reset(2);
    for (int i = 0; i < 256; i++) coefs[i] = 16'(i);
    build_expected(8, 0, 256);
    send(0, 256);
    drain();
    check(got_q.size() == 256, "d8_byte_count", got_q.size(), 256);
    mism = 0;
    for (int k = 0; k < 256; k++) if (int'(got_q[k]) != k) mism++;
    check(mism == 0, "d8_byte_eq_index", mism, 0);
    check(stall_n == 0, "d8_no_stall", stall_n, 0);
    check(first_take_cyc - first_acc_cyc == 2, "d8_first_latency", first_take_cyc - first_acc_cyc, 2);
    check(last_take_cyc - first_take_cyc == 255, "d8_one_per_cycle", last_take_cyc - first_take_cyc, 255);
    check(last_idx == 255, "d8_last_pos", last_idx, 255);

    // D=1 alternating bits.
    sel = 2;
    do_reset(2);
    for (int i = 0; i < 256; i++) coefs[i] = 16'(i % 2);
    build_expected(1, 0, 256);
    send(0, 256);
    drain();
    check(got_q.size() == 32, "d1_byte_count", got_q.size(), 32);
    mism = 0;
    for (int k = 0; k < 32; k++) if (got_q[k] != 8'hAA) mism++;
    check(mism == 0, "d1_all_aa", mism, 0);
    check(last_cnt == 1 && last_idx == 31, "d1_last_pos", last_idx, 31);
    check(stall_n == 0, "d1_no_stall", stall_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_encode_stream.md
Name: byte_encode_stream

Overview:
- Sequential ML-KEM ByteEncode_d: the streaming counterpart of the combinational byte decoder.
- Accepts 256 coefficients per polynomial, one per handshake.
- Packs the low D bits of each coefficient LSB-first into a continuous bit stream.
- Emits the packed polynomial as 32*D bytes on a byte-wide valid/ready stream.
- Sits between the compress/NTT datapath and the ciphertext/key byte serializer.

Parameters:
- D, 12, bits per coefficient; legal 1..12. Elaboration error otherwise.
- IN_WIDTH, 16, width of the incoming coefficient word; must be >= D.
- ACC_W, 24, bit-accumulator width. Must be >= D+8, so push and pop can occur in the same cycle.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- coef_i  in  IN_WIDTH  input coefficient.
- coef_valid_i  in  1  coef_i valid.
- coef_ready_o  out  1  block can accept coef_i this cycle.
- byte_o  out  8  packed output byte.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  downstream accepts byte_o.
- byte_last_o  out  1  byte_o is the final byte (index 32*D-1) of the polynomial. Qualified by byte_valid_o.
- range_err_o  out  1  sticky flag, D=12 only: an accepted coef_i was >= 3329. Tied 0 for D<12.

Behaviour:
- Reset values: coef_ready_o=0 in the reset cycle, then 1. byte_o=0, byte_valid_o=0, byte_last_o=0, range_err_o=0. Accumulator, bit count (cnt), coefficient counter and byte counter are all 0.
- Reset mid-polynomial: discards all buffered bits and counters. The next accepted coefficient is coefficient 0 of a new polynomial.
- Bit order:
  - Bit j of coefficient i maps to stream bit i*D+j.
  - Stream bit 8k+b maps to bit b of output byte k.
  - Must match the combinational decoder exactly.
- Value:
  - Only coef_i[D-1:0] is packed (mod 2^D; mod q is the caller's job for D=12).
  - D=12: if an accepted coef_i[11:0] >= 3329, set range_err_o; it clears only on reset.
  - Upper IN_WIDTH-D bits are ignored.
- coef_ready_o:
  - Registered function of state only: 1 when cnt <= ACC_W-D.
  - No combinational path from byte_ready_i or coef_valid_i.
- Push (coef_valid_i && coef_ready_o): the D bits are written at accumulator positions [cnt +: D]; cnt increases by D.
- Pop (load of the output register):
  - Occurs when cnt >= 8 and the output register is empty or being consumed this cycle (byte_valid_o && byte_ready_i).
  - accumulator[7:0] moves into byte_o, the accumulator shifts right by 8, and cnt decreases by 8.
- Simultaneous push and pop: the pop shift applies first; the pushed bits land at position cnt-8. Net cnt change is D-8.
- Latency: a coefficient accepted at edge t can produce byte_valid_o=1 after edge t+1 at the earliest (one output-register stage).
- Output hold: while byte_valid_o && !byte_ready_i, byte_o and byte_last_o stay stable. Accumulator fill continues until coef_ready_o drops.
- Throughput with byte_ready_i held high:
  - D <= 8: one coefficient per cycle, no input stall.
  - D = 12: output-bound at one byte/cycle; coef_ready_o deasserts about 1 cycle in 3.
- Counters:
  - Coefficient counter 0..255 and byte counter 0..32*D-1 wrap to 0 at polynomial end.
  - 256*D is a multiple of 8, so cnt is exactly 0 after the last byte pops; no padding or flush is ever needed.
  - Back-to-back polynomials stream without a gap.
- byte_last_o: set when the byte with counter value 32*D-1 loads into the output register; cleared on the next load or on reset.
- No state machine beyond the counters; the block is a pure elastic packer.

Test Plan:
- D=12, f[i]=i mod 3329 for i=0..255, byte_ready_i=1:
  - Exactly 384 bytes out. Byte0=0x00, byte1=0x10, byte2=0x00.
  - Decoder round-trip equals f.
  - byte_last_o high only on byte 383; range_err_o stays 0.
- D=1, f[i]=i mod 2:
  - 32 bytes, each 0xAA. byte_last_o on byte 31.
  - coef_ready_o never drops.
- D=8, f[i]=i, byte_ready_i=1, coef_valid_i=1 continuously:
  - Byte k = k.
  - One byte per cycle after the first-byte latency of 1 cycle; no coef_ready_o stall.
- D=12, byte_ready_i toggled by random backpressure:
  - byte_o held stable while stalled.
  - coef_ready_o=0 whenever cnt > 12.
  - No lost or duplicated bytes; decoder round-trip passes.
- D=12, coefficient 5 = 3329, rest 0:
  - range_err_o rises the cycle after acceptance and stays set.
  - Output bits still equal 3329[11:0].
- D=12, rst_i asserted after 100 coefficients, then a full fresh polynomial:
  - All outputs 0 during reset.
  - Post-reset stream of 384 bytes matches the fresh input alone.
